// File: rtl/dfp_burst_adapter.sv
// dfp_burst_adapter: serializes cacheline writes into beat bursts and assembles read bursts into a line
module dfp_burst_adapter #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64,
    localparam int BEATS = LINE_BITS / BEAT_BITS,
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);
    localparam int BW = $clog2(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [31:0] OFF_MASK = (32'd1 << OFFSET_BITS) - 32'd1;

    typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_DATA, RESP} state_t;

    state_t state;
    logic [BW-1:0] beat, nb;
    logic [LINE_BITS-1:0] line, line_nxt;

    // next beat index and the line with the incoming read beat merged into slice beat
    always_comb begin
        nb = beat + 1'b1;
        line_nxt = line;
        line_nxt[beat*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
    end

    // control FSM; every bmem and dfp output is a register updated alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            line       <= '0;
            dfp_rdata  <= '0;
            dfp_resp   <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (dfp_read | dfp_write) begin
                    bmem_addr <= dfp_addr & ~OFF_MASK;
                    beat      <= '0;
                    if (dfp_write) begin
                        line       <= dfp_wdata;
                        bmem_wdata <= dfp_wdata[BEAT_BITS-1:0];
                        bmem_write <= 1'b1;
                        state      <= WR;
                    end else begin
                        bmem_read <= 1'b1;
                        state     <= RD_CMD;
                    end
                end
                WR: if (bmem_ready) begin
                    beat <= nb;
                    if (beat == LAST) begin
                        bmem_write <= 1'b0;
                        bmem_wdata <= '0;
                        bmem_addr  <= '0;
                        dfp_resp   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        bmem_wdata <= line[nb*BEAT_BITS +: BEAT_BITS];
                    end
                end
                RD_CMD: if (bmem_ready) begin
                    bmem_read <= 1'b0;
                    state     <= RD_DATA;
                end
                RD_DATA: if (bmem_rvalid) begin
                    line <= line_nxt;
                    beat <= nb;
                    if (beat == LAST) begin
                        dfp_rdata <= line_nxt;
                        bmem_addr <= '0;
                        dfp_resp  <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    dfp_resp <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dfp_burst_adapter.sv
// tb_dfp_burst_adapter: randomized transaction-level checks of dfp_burst_adapter against a line/beat model
module tb_dfp_burst_adapter;
    localparam int LB = 256;
    localparam int BB = 64;
    localparam int NB = LB / BB;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] dfp_addr;
    logic dfp_read, dfp_write;
    logic [LB-1:0] dfp_wdata, dfp_rdata;
    logic dfp_resp;
    logic [31:0] bmem_addr;
    logic bmem_read, bmem_write;
    logic [BB-1:0] bmem_wdata, bmem_rdata;
    logic bmem_ready, bmem_rvalid;

    int passed = 0;
    int total = 0;
    logic [LB-1:0] exp_rdata;

    dfp_burst_adapter dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a - (a % 32);
    endfunction

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic garbage();
        dfp_read  = 1'($urandom);
        dfp_write = 1'($urandom);
        dfp_addr  = $urandom;
        dfp_wdata = rand_line();
    endtask

    task automatic quiet();
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [LB-1:0] d, input logic rd_too, input logic [15:0] rmask);
        int k = 0;
        int cyc = 0;
        dfp_addr = a; dfp_wdata = d; dfp_write = 1'b1; dfp_read = rd_too;
        bmem_ready = 1'($urandom); bmem_rvalid = 1'($urandom); bmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        while (k < NB && cyc < 64) begin
            check("wr_valid", bmem_write, 1);
            check("wr_addr", bmem_addr, align(a));
            check("wr_data", bmem_wdata, d[k*BB +: BB]);
            check("wr_noread", bmem_read, 0);
            check("wr_noresp", dfp_resp, 0);
            check("wr_rdata_hold", dfp_rdata, exp_rdata);
            garbage();
            bmem_rvalid = 1'($urandom); bmem_rdata = {$urandom, $urandom};
            bmem_ready = cyc < 16 ? rmask[cyc] : 1'b1;
            @(negedge clk);
            if (bmem_ready) k++;
            cyc++;
        end
        check("wr_resp", dfp_resp, 1);
        check("wr_end_valid", bmem_write, 0);
        check("wr_end_data", bmem_wdata, 0);
        check("wr_end_rdata", dfp_rdata, exp_rdata);
        quiet();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [LB-1:0] l, input logic [15:0] rmask,
                           input int gap_lo, input int gap_hi, input int abort_after);
        int cyc = 0;
        logic done = 1'b0;
        dfp_addr = a; dfp_read = 1'b1; dfp_write = 1'b0;
        bmem_ready = 1'($urandom); bmem_rvalid = 1'($urandom); bmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        while (!done && cyc < 64) begin
            check("rd_cmd", bmem_read, 1);
            check("rd_addr", bmem_addr, align(a));
            check("rd_nowrite", bmem_write, 0);
            check("rd_cmd_noresp", dfp_resp, 0);
            check("rd_cmd_hold", dfp_rdata, exp_rdata);
            garbage();
            bmem_rvalid = 1'($urandom); bmem_rdata = {$urandom, $urandom};
            bmem_ready = cyc < 16 ? rmask[cyc] : 1'b1;
            done = bmem_ready;
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < NB; k++) begin
            int gap;
            if (k == abort_after) return;
            gap = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g <= gap; g++) begin
                check("rd_data_noread", bmem_read, 0);
                check("rd_data_noresp", dfp_resp, 0);
                check("rd_data_hold", dfp_rdata, exp_rdata);
                garbage();
                bmem_ready = 1'($urandom);
                bmem_rvalid = g == gap;
                bmem_rdata = g == gap ? l[k*BB +: BB] : {$urandom, $urandom};
                @(negedge clk);
            end
        end
        bmem_rvalid = 1'b0;
        exp_rdata = l;
        check("rd_resp", dfp_resp, 1);
        check("rd_line", dfp_rdata, exp_rdata);
        quiet();
    endtask

    task automatic to_idle();
        bmem_rvalid = 1'($urandom); bmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        check("idle_noresp", dfp_resp, 0);
        check("idle_addr", bmem_addr, 0);
        check("idle_noread", bmem_read, 0);
        check("idle_nowrite", bmem_write, 0);
        check("idle_wdata", bmem_wdata, 0);
        check("idle_rdata", dfp_rdata, exp_rdata);
    endtask

    initial begin
        logic [LB-1:0] l;
        rst = 1'b1; quiet(); dfp_addr = '0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = '0;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_resp", dfp_resp, 0);
        check("rst_rdata", dfp_rdata, 0);
        check("rst_addr", bmem_addr, 0);
        check("rst_bus", {bmem_read, bmem_write}, 0);
        rst = 1'b0;
        @(negedge clk);

        l = {64'hD3D3_D3D3_3333_3333, 64'hD2D2_D2D2_2222_2222, 64'hD1D1_D1D1_1111_1111, 64'hD0D0_D0D0_0000_0000};
        do_write(32'h0000_1234, l, 1'b0, 16'hFFFF);
        check("wr_align_const", align(32'h0000_1234), 32'h0000_1220);
        to_idle();
        do_write(32'h0000_1234, l, 1'b0, 16'hFFF5);
        to_idle();

        l = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        do_read(32'h0000_0080, l, 16'hFFF8, 1, 1, NB);
        to_idle();

        do_write(32'h0000_4567, rand_line(), 1'b1, 16'hFFFF);
        to_idle();

        do_write(32'h0000_0100, rand_line(), 1'b0, 16'hFFFF);
        dfp_read = 1'b1; dfp_addr = 32'h0000_0200;
        to_idle();
        do_read(32'h0000_0200, rand_line(), 16'hFFFF, 0, 0, NB);
        to_idle();

        for (int i = 0; i < 30; i++) begin
            int op = $urandom_range(2, 0);
            if (op == 1) do_read($urandom, rand_line(), 16'($urandom), 0, 3, NB);
            else do_write($urandom, rand_line(), op == 2, 16'($urandom));
            to_idle();
        end

        do_read(32'h0000_0040, rand_line(), 16'hFFFF, 0, 1, 2);
        rst = 1'b1;
        #1;
        exp_rdata = '0;
        check("arst_resp", dfp_resp, 0);
        check("arst_rdata", dfp_rdata, 0);
        check("arst_addr", bmem_addr, 0);
        check("arst_bus", {bmem_read, bmem_write}, 0);
        check("arst_wdata", bmem_wdata, 0);
        quiet(); bmem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
            @(negedge clk);
            check("post_rst_noresp", dfp_resp, 0);
            check("post_rst_rdata", dfp_rdata, 0);
        end
        bmem_rvalid = 1'b0;
        @(negedge clk);
        l = rand_line();
        do_read(32'h0000_0060, l, 16'hFFFF, 0, 2, NB);
        check("rd_beat0_low", dfp_rdata[BB-1:0], l[BB-1:0]);
        to_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dfp_burst_adapter.md
# dfp_burst_adapter

Memory-side responder for the cache's downstream-facing port (DFP). It accepts single-cycle cacheline read and write requests from the cache and its flush controller, serializes writes into 64-bit bursts and assembles read bursts back into a 256-bit line. It returns exactly one `dfp_resp` pulse per request. It sits between the mutative cache and the burst memory model.

## Interface
- `LINE_BITS`, 256: cacheline width; must be a multiple of `BEAT_BITS`.
- `BEAT_BITS`, 64: burst beat width.
- `BEATS` (derived), `LINE_BITS/BEAT_BITS` = 4: beats per line.
- `OFFSET_BITS` (derived), `$clog2(LINE_BITS/8)` = 5: line byte-offset bits.
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `dfp_addr` in 32: request byte address, sampled on the accept cycle.
- `dfp_read` in 1: read request.
- `dfp_write` in 1: write request.
- `dfp_wdata` in `LINE_BITS`: write line, sampled on the accept cycle.
- `dfp_rdata` out `LINE_BITS`: assembled read line, registered.
- `dfp_resp` out 1: one-cycle completion pulse, registered.
- `bmem_addr` out 32: burst address, line-aligned.
- `bmem_read` out 1: burst read command.
- `bmem_write` out 1: burst write beat valid.
- `bmem_wdata` out `BEAT_BITS`: current write beat.
- `bmem_ready` in 1: memory accepts the command or beat this cycle.
- `bmem_rdata` in `BEAT_BITS`: read beat.
- `bmem_rvalid` in 1: read beat valid.

## Operation
- States:
  - IDLE: waiting for a request.
  - WR: streaming write beats.
  - RD_CMD: issuing the read command.
  - RD_DATA: collecting read beats.
  - RESP: completion cycle.
- Beat counter `beat`, width `$clog2(BEATS)`.
- **IDLE → accept.**
  - A request is accepted on any IDLE cycle with `dfp_read|dfp_write`.
  - On accept, latch `{dfp_addr[31:OFFSET_BITS], OFFSET_BITS'0}` into the address register and clear `beat`.
  - For a write, also latch `dfp_wdata`.
  - The requester may deassert the request on the next cycle; it is not required to hold it.
  - If `dfp_read` and `dfp_write` are both high, the write wins and the read is dropped.
- **WR.**
  - `bmem_write`=1.
  - `bmem_addr` = latched address, constant for the whole burst.
  - `bmem_wdata` = line[`beat`*BEAT_BITS +: BEAT_BITS], lowest beat first.
  - `beat` advances only on a cycle with `bmem_ready`=1.
  - The accepted beat with `beat`==BEATS-1 moves the FSM to RESP.
- **RD_CMD.**
  - `bmem_read`=1 and `bmem_addr` = latched address.
  - Stays in RD_CMD until `bmem_ready`=1, then goes to RD_DATA.
- **RD_DATA.**
  - Each `bmem_rvalid` cycle writes `bmem_rdata` into line slice `beat` and increments `beat`.
  - Beats may arrive with gaps.
  - The `beat`==BEATS-1 rvalid goes to RESP.
  - The assembled line is copied to `dfp_rdata` on that same edge.
- **RESP.**
  - `dfp_resp`=1 for exactly this one cycle, then IDLE.
  - A request presented during RESP is ignored; the requester protocol forbids it.
- Requests presented outside IDLE are ignored; no queuing.
- `bmem_rvalid` outside RD_DATA is ignored.
- `dfp_rdata` holds its value until the next read completes; writes do not alter it.
- `bmem_wdata` is 0 outside WR; `bmem_addr` is 0 in IDLE.
- The counter wraps to 0 on the final beat.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, `beat`=0.
  - `dfp_resp`=0, `dfp_rdata`=0.
  - `bmem_read`=0, `bmem_write`=0, `bmem_addr`=0, `bmem_wdata`=0.
  - Internal line and address registers are cleared.
- Reset mid-burst aborts the transfer; no `dfp_resp` is issued afterwards.
- `bmem_*` outputs are driven from state and registers only, with no combinational path from `dfp_*`.
- `dfp_resp` is registered: high in the cycle after the final beat.
- Write, request at cycle T with `bmem_ready` constantly 1: beats at T+1..T+4, `dfp_resp` at T+5.
- Read, request at T with `bmem_ready`=1: `bmem_read` at T+1. If the last rvalid is at cycle R, `dfp_resp` and valid `dfp_rdata` are at R+1.
- Back-to-back: a new request is accepted at the earliest one cycle after the `dfp_resp` cycle.
- Each `bmem_ready`=0 cycle in WR or RD_CMD adds exactly one cycle of latency.

## Test plan
- **Write burst, ready always 1.**
  - Stimulus: `dfp_write` pulse with addr 0x0000_1234 and wdata beats {D3,D2,D1,D0}.
  - Required: `bmem_addr`=0x0000_1220 on 4 consecutive cycles with wdata D0,D1,D2,D3, then a single `dfp_resp`.
  - Required: the request is dropped after one cycle and the result is unchanged.
- **Write with stalls.**
  - Stimulus: `bmem_ready` low on the 2nd and 4th cycles of WR.
  - Required: no beat is skipped or repeated; `dfp_resp` arrives 2 cycles later than in the no-stall case.
- **Read with gapped beats.**
  - Stimulus: read at 0x80; `bmem_ready` low for 3 cycles, then high.
  - Stimulus: rvalid beats A,B,C,D with 1-cycle gaps between them.
  - Required: `bmem_read` is held for 4 cycles.
  - Required: `dfp_rdata`={D,C,B,A} and `dfp_resp` in the cycle after D.
- **Simultaneous read and write, then stray traffic.**
  - Stimulus: `dfp_read` and `dfp_write` both high in the same cycle.
  - Required: only a write burst occurs.
  - Stimulus: `bmem_rvalid` pulses while in IDLE or WR.
  - Required: `dfp_rdata` is unchanged.
- **Back-to-back requests.**
  - Stimulus: a write, then a read presented in the `dfp_resp` cycle, then the same read presented one cycle later.
  - Required: the first read is ignored and the second is accepted.
- **Reset mid-read.**
  - Stimulus: assert `rst` after 2 of 4 beats have arrived.
  - Required: all outputs are 0 immediately and no `dfp_resp` is issued.
  - Stimulus: a fresh read after reset.
  - Required: it completes normally, and beat 0 lands in bits [63:0].
